// File: rtl/alu_ctrl_stage.sv
// ID/EX stage: decodes an RV32I instruction into ALU control, operand-B select and immediate.
// One-cycle latency; stall holds the register, flush loads a bubble, a seen ECALL bubbles every later load.
module alu_ctrl_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [3:0]       ex_alu_ctrl,
  output logic             ex_alu_src_imm,
  output logic [31:0]      ex_imm,
  output logic             ex_illegal,
  output logic             ex_halt,
  output logic             halt_seen,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SLR = 4'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;

  assign opcode = id_inst[6:0];
  assign funct3 = id_inst[14:12];
  assign funct7 = id_inst[31:25];
  assign imm_i  = {{20{id_inst[31]}}, id_inst[31:20]};
  assign imm_s  = {{20{id_inst[31]}}, id_inst[31:25], id_inst[11:7]};
  assign imm_b  = {{19{id_inst[31]}}, id_inst[31], id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0};
  assign imm_j  = {{11{id_inst[31]}}, id_inst[31], id_inst[19:12], id_inst[20], id_inst[30:21], 1'b0};

  logic        ok;
  logic [3:0]  op_ctrl;
  logic        op_src;
  logic [31:0] op_imm;
  logic        op_halt;

  always_comb begin
    ok      = 1'b0;
    op_ctrl = ALU_ADD;
    op_src  = 1'b0;
    op_imm  = '0;
    op_halt = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct3)
          3'b000: begin
            ok      = (funct7 == 7'h00) || (funct7 == 7'h20);
            op_ctrl = funct7[5] ? ALU_SUB : ALU_ADD;
          end
          3'b111:  begin ok = (funct7 == 7'h00); op_ctrl = ALU_AND; end
          3'b110:  begin ok = (funct7 == 7'h00); op_ctrl = ALU_OR;  end
          3'b100:  begin ok = (funct7 == 7'h00); op_ctrl = ALU_XOR; end
          3'b001:  begin ok = (funct7 == 7'h00); op_ctrl = ALU_SLL; end
          3'b101:  begin ok = (funct7 == 7'h00); op_ctrl = ALU_SLR; end
          default: ok = 1'b0;
        endcase
      end
      OP_I: begin
        op_src = 1'b1;
        op_imm = imm_i;
        case (funct3)
          3'b000:  begin ok = 1'b1; op_ctrl = ALU_ADD; end
          3'b111:  begin ok = 1'b1; op_ctrl = ALU_AND; end
          3'b110:  begin ok = 1'b1; op_ctrl = ALU_OR;  end
          3'b100:  begin ok = 1'b1; op_ctrl = ALU_XOR; end
          3'b001:  begin ok = (funct7 == 7'h00); op_ctrl = ALU_SLL; end
          3'b101:  begin ok = (funct7 == 7'h00); op_ctrl = ALU_SLR; end
          default: ok = 1'b0;
        endcase
      end
      OP_LOAD, OP_JALR: begin ok = 1'b1; op_src = 1'b1; op_imm = imm_i; end
      OP_STORE:         begin ok = 1'b1; op_src = 1'b1; op_imm = imm_s; end
      OP_BRANCH:        begin ok = 1'b1; op_ctrl = ALU_SUB; op_imm = imm_b; end
      OP_JAL:           begin ok = 1'b1; op_src = 1'b1; op_imm = imm_j; end
      OP_SYSTEM: begin
        ok      = (id_inst == 32'h0000_0073);
        op_halt = ok;
      end
      default: ok = 1'b0;
    endcase
  end

  // Illegal encodings collapse to a harmless ADD with rs2 and a zero immediate.
  logic [3:0]  dec_ctrl;
  logic        dec_src;
  logic [31:0] dec_imm;
  logic        dec_illegal;
  logic        dec_halt;

  assign dec_illegal = !ok;
  assign dec_ctrl    = ok ? op_ctrl : ALU_ADD;
  assign dec_src     = ok && op_src;
  assign dec_imm     = ok ? op_imm : '0;
  assign dec_halt    = ok && op_halt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid       <= 1'b0;
      ex_alu_ctrl    <= '0;
      ex_alu_src_imm <= 1'b0;
      ex_imm         <= '0;
      ex_illegal     <= 1'b0;
      ex_halt        <= 1'b0;
      halt_seen      <= 1'b0;
      illegal_count  <= '0;
    end else if (flush || (!stall && (halt_seen || !id_valid))) begin
      ex_valid       <= 1'b0;
      ex_alu_ctrl    <= '0;
      ex_alu_src_imm <= 1'b0;
      ex_imm         <= '0;
      ex_illegal     <= 1'b0;
      ex_halt        <= 1'b0;
    end else if (!stall) begin
      ex_valid       <= 1'b1;
      ex_alu_ctrl    <= dec_ctrl;
      ex_alu_src_imm <= dec_src;
      ex_imm         <= dec_imm;
      ex_illegal     <= dec_illegal;
      ex_halt        <= dec_halt;
      if (dec_illegal && (illegal_count != CNT_MAX)) illegal_count <= illegal_count + CNT_ONE;
      if (dec_halt) halt_seen <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Randomized bench for alu_ctrl_stage: instructions are built from random fields together with their
// expected decode, and an abstract pipeline-register model is compared to the DUT every cycle.
module tb_alu_ctrl_stage;

  localparam int CNT_W = 2;
  localparam int CMAX  = 3;

  localparam logic [3:0] A_ADD = 4'd0;
  localparam logic [3:0] A_SUB = 4'd1;
  localparam logic [3:0] A_AND = 4'd2;
  localparam logic [3:0] A_OR  = 4'd3;
  localparam logic [3:0] A_XOR = 4'd4;
  localparam logic [3:0] A_SLL = 4'd5;
  localparam logic [3:0] A_SLR = 4'd6;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic        src;
    logic [31:0] imm;
    logic        ill;
    logic        halt;
  } dec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             id_valid = 1'b0;
  logic [31:0]      id_inst = '0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic             ex_valid;
  logic [3:0]       ex_alu_ctrl;
  logic             ex_alu_src_imm;
  logic [31:0]      ex_imm;
  logic             ex_illegal;
  logic             ex_halt;
  logic             halt_seen;
  logic [CNT_W-1:0] illegal_count;

  alu_ctrl_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_inst(id_inst),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_alu_src_imm(ex_alu_src_imm), .ex_imm(ex_imm), .ex_illegal(ex_illegal),
    .ex_halt(ex_halt), .halt_seen(halt_seen), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic run_chk = 1'b0;

  // Model of what EX must hold.
  logic m_valid = 1'b0;
  dec_t m_dec   = '0;
  logic m_hs    = 1'b0;
  int   m_cnt   = 0;

  function automatic dec_t mk(logic [3:0] c, logic s, logic [31:0] i, logic il, logic h);
    dec_t d;
    d.ctrl = c; d.src = s; d.imm = i; d.ill = il; d.halt = h;
    return d;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_dec = '0; m_hs = 1'b0; m_cnt = 0;
  endtask

  task automatic model_edge(logic v, dec_t d, logic st, logic fl);
    if (fl) begin
      m_valid = 1'b0; m_dec = '0;
    end else if (st) begin
      // everything holds
    end else if (m_hs || !v) begin
      m_valid = 1'b0; m_dec = '0;
    end else begin
      m_valid = 1'b1; m_dec = d;
      if (d.ill && m_cnt < CMAX) m_cnt++;
      if (d.halt) m_hs = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      chk("ex_valid", 32'(ex_valid), 32'(m_valid));
      chk("ex_alu_ctrl", 32'(ex_alu_ctrl), 32'(m_dec.ctrl));
      chk("ex_alu_src_imm", 32'(ex_alu_src_imm), 32'(m_dec.src));
      chk("ex_imm", ex_imm, m_dec.imm);
      chk("ex_illegal", 32'(ex_illegal), 32'(m_dec.ill));
      chk("ex_halt", 32'(ex_halt), 32'(m_dec.halt));
      chk("halt_seen", 32'(halt_seen), 32'(m_hs));
      chk("illegal_count", 32'(illegal_count), 32'(m_cnt));
    end
  end

  // Called at posedge+2; drives inputs, takes one edge, returns at the next posedge+2.
  task automatic step(logic v, logic [31:0] inst, dec_t d, logic st, logic fl);
    id_valid = v; id_inst = inst; stall = st; flush = fl;
    @(posedge clk);
    model_edge(v, d, st, fl);
    #2;
  endtask

  // Asynchronous pulse away from any clock edge.
  task automatic async_reset();
    reset = 1'b1;
    #1;
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  task automatic gen(output logic [31:0] inst, output dec_t d);
    int          kind;
    int          sub;
    logic [4:0]  rd, rs1, rs2, sh;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] i12;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [31:0] r;
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); sh = 5'($urandom);
    f3 = 3'($urandom); i12 = 12'($urandom); r = $urandom;
    sub  = $urandom_range(0, 3);
    kind = $urandom_range(0, 23);
    if (kind == 23 && $urandom_range(0, 3) != 0) kind = 0;
    d = mk(A_ADD, 1'b0, 32'h0, 1'b1, 1'b0);
    inst = 32'h0;
    case (kind)
      0: begin inst = {7'h00, rs2, rs1, 3'b000, rd, 7'h33}; d = mk(A_ADD, 0, 0, 0, 0); end
      1: begin inst = {7'h20, rs2, rs1, 3'b000, rd, 7'h33}; d = mk(A_SUB, 0, 0, 0, 0); end
      2: begin inst = {7'h00, rs2, rs1, 3'b111, rd, 7'h33}; d = mk(A_AND, 0, 0, 0, 0); end
      3: begin inst = {7'h00, rs2, rs1, 3'b110, rd, 7'h33}; d = mk(A_OR,  0, 0, 0, 0); end
      4: begin inst = {7'h00, rs2, rs1, 3'b100, rd, 7'h33}; d = mk(A_XOR, 0, 0, 0, 0); end
      5: begin inst = {7'h00, rs2, rs1, 3'b001, rd, 7'h33}; d = mk(A_SLL, 0, 0, 0, 0); end
      6: begin inst = {7'h00, rs2, rs1, 3'b101, rd, 7'h33}; d = mk(A_SLR, 0, 0, 0, 0); end
      7:  begin inst = {i12, rs1, 3'b000, rd, 7'h13}; d = mk(A_ADD, 1, {{20{i12[11]}}, i12}, 0, 0); end
      8:  begin inst = {i12, rs1, 3'b111, rd, 7'h13}; d = mk(A_AND, 1, {{20{i12[11]}}, i12}, 0, 0); end
      9:  begin inst = {i12, rs1, 3'b110, rd, 7'h13}; d = mk(A_OR,  1, {{20{i12[11]}}, i12}, 0, 0); end
      10: begin inst = {i12, rs1, 3'b100, rd, 7'h13}; d = mk(A_XOR, 1, {{20{i12[11]}}, i12}, 0, 0); end
      11: begin inst = {7'h00, sh, rs1, 3'b001, rd, 7'h13}; d = mk(A_SLL, 1, 32'(sh), 0, 0); end
      12: begin inst = {7'h00, sh, rs1, 3'b101, rd, 7'h13}; d = mk(A_SLR, 1, 32'(sh), 0, 0); end
      13: begin inst = {i12, rs1, f3, rd, 7'h03}; d = mk(A_ADD, 1, {{20{i12[11]}}, i12}, 0, 0); end
      14: begin inst = {i12[11:5], rs2, rs1, f3, i12[4:0], 7'h23}; d = mk(A_ADD, 1, {{20{i12[11]}}, i12}, 0, 0); end
      15: begin
        b13  = {r[12:1], 1'b0};
        inst = {b13[12], b13[10:5], rs2, rs1, f3, b13[4:1], b13[11], 7'h63};
        d    = mk(A_SUB, 0, {{19{b13[12]}}, b13}, 0, 0);
      end
      16: begin
        j21  = {r[20:1], 1'b0};
        inst = {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'h6F};
        d    = mk(A_ADD, 1, {{11{j21[20]}}, j21}, 0, 0);
      end
      17: begin inst = {i12, rs1, f3, rd, 7'h67}; d = mk(A_ADD, 1, {{20{i12[11]}}, i12}, 0, 0); end
      18: begin  // illegal R-type: SLT, SLTU, SRA, bad funct7
        case (sub)
          0: inst = {7'h00, rs2, rs1, 3'b010, rd, 7'h33};
          1: inst = {7'h00, rs2, rs1, 3'b011, rd, 7'h33};
          2: inst = {7'h20, rs2, rs1, 3'b101, rd, 7'h33};
          default: begin
            f7 = r[6:0];
            if (f7 == 7'h00 || f7 == 7'h20) f7 = 7'h01;
            f3 = (r[8:7] == 2'd0) ? 3'b000 : (r[8:7] == 2'd1) ? 3'b001 : 3'b101;
            inst = {f7, rs2, rs1, f3, rd, 7'h33};
          end
        endcase
      end
      19: begin  // illegal I-type: SLTI, SLTIU, SRAI, shift with nonzero upper bits
        case (sub)
          0: inst = {i12, rs1, 3'b010, rd, 7'h13};
          1: inst = {i12, rs1, 3'b011, rd, 7'h13};
          2: inst = {7'h20, sh, rs1, 3'b101, rd, 7'h13};
          default: inst = {r[6:0] | 7'h01, sh, rs1, r[7] ? 3'b001 : 3'b101, rd, 7'h13};
        endcase
      end
      20: inst = {r[31:12], rd, r[0] ? 7'b0110111 : 7'b0010111};
      21: begin
        case (sub)
          0: inst = {r[31:7], 7'b0001111};
          1: inst = {r[31:7], 7'b1111111};
          2: inst = {r[31:7], 7'b0000000};
          default: inst = {r[31:7], 7'b1010011};
        endcase
      end
      22: inst = {r[31:21], 1'b1, r[19:7], 7'h73};
      default: begin inst = 32'h0000_0073; d = mk(A_ADD, 0, 0, 0, 1); end
    endcase
  endtask

  dec_t d_add, d_sub, d_addi, d_beq, d_sra, d_ecall;

  initial begin
    logic [31:0] ri;
    dec_t        rd_;
    logic        rv, rs, rf;

    d_add   = mk(A_ADD, 0, 32'h0, 0, 0);
    d_sub   = mk(A_SUB, 0, 32'h0, 0, 0);
    d_addi  = mk(A_ADD, 1, 32'hFFFF_FFFF, 0, 0);
    d_beq   = mk(A_SUB, 0, 32'hFFFF_FFFC, 0, 0);
    d_sra   = mk(A_ADD, 0, 32'h0, 1, 0);
    d_ecall = mk(A_ADD, 0, 32'h0, 0, 1);

    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    run_chk = 1'b1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_count", 32'(illegal_count), 32'd0);
    chk("rst_halt_seen", 32'(halt_seen), 32'd0);

    // add, then asynchronous reset mid-cycle
    step(1, 32'h002081B3, d_add, 0, 0);
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_ctrl", 32'(ex_alu_ctrl), 32'(A_ADD));
    chk("add_src", 32'(ex_alu_src_imm), 32'd0);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(ex_valid), 32'd0);
    model_reset();
    #1;
    reset = 1'b0;

    step(1, 32'h402081B3, d_sub, 0, 0);
    chk("sub_ctrl", 32'(ex_alu_ctrl), 32'(A_SUB));
    step(1, 32'hFFF00093, d_addi, 0, 0);
    chk("addi_src", 32'(ex_alu_src_imm), 32'd1);
    chk("addi_imm", ex_imm, 32'hFFFF_FFFF);
    step(1, 32'hFE208EE3, d_beq, 0, 0);
    chk("beq_ctrl", 32'(ex_alu_ctrl), 32'(A_SUB));
    chk("beq_imm", ex_imm, 32'hFFFF_FFFC);

    // stall holds, flush beats stall
    step(1, 32'h002081B3, d_add, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h402081B3, d_sub, 1, 0);
      chk("stall_hold_ctrl", 32'(ex_alu_ctrl), 32'(A_ADD));
    end
    step(1, 32'hFFF00093, d_addi, 1, 1);
    chk("stall_flush_valid", 32'(ex_valid), 32'd0);
    chk("stall_flush_imm", ex_imm, 32'h0);

    // illegal counting and saturation
    step(1, 32'h4020D1B3, d_sra, 0, 0);
    chk("sra_illegal", 32'(ex_illegal), 32'd1);
    chk("sra_count", 32'(illegal_count), 32'd1);
    for (int i = 0; i < 4; i++) step(1, 32'h4020D1B3, d_sra, 0, 0);
    chk("sat_count", 32'(illegal_count), 32'd3);
    async_reset();
    step(1, 32'h4020D1B3, d_sra, 1, 0);
    chk("stall_ill_count", 32'(illegal_count), 32'd0);
    step(1, 32'h4020D1B3, d_sra, 0, 1);
    chk("flush_ill_count", 32'(illegal_count), 32'd0);

    // ECALL
    step(1, 32'h0000_0073, d_ecall, 0, 1);
    chk("flush_ecall_hs", 32'(halt_seen), 32'd0);
    step(1, 32'h0000_0073, d_ecall, 0, 0);
    chk("ecall_halt", 32'(ex_halt), 32'd1);
    chk("ecall_hs", 32'(halt_seen), 32'd1);
    step(1, 32'h002081B3, d_add, 0, 0);
    chk("post_halt_valid", 32'(ex_valid), 32'd0);
    async_reset();

    // id_valid low with a legal instruction
    step(0, 32'hFFF00093, d_addi, 0, 0);
    chk("novalid_valid", 32'(ex_valid), 32'd0);
    chk("novalid_imm", ex_imm, 32'h0);

    for (int n = 0; n < 4000; n++) begin
      gen(ri, rd_);
      rv = ($urandom_range(0, 9) < 8);
      rs = ($urandom_range(0, 99) < 15);
      rf = ($urandom_range(0, 99) < 10);
      step(rv, ri, rd_, rs, rf);
      if ($urandom_range(0, 99) < 2) async_reset();
    end

    @(posedge clk);
    #2;
    run_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
